sdram_rr_arbiter: RTL

// - Shares one sdram controller port (toggle req/ack handshake, 16-bit word, addr[24:1]) among NCLI clients.
// - Round-robin grant, so no client starves; the controller's fixed-priority ports stay free for time-critical masters.
// - Sits between the client masters (e.g. save-RAM, CD buffer, debug loader) and a single sdram port.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_rr_arbiter_rr_pick.sv | 33 +++
 rtl/sdram_rr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the sdram round-robin arbiter: FSM state encoding and
// the grant/pointer width helper.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Grant/pointer width for a given client count; never narrower than one bit.
  function automatic int gw_of(input int ncli);
    return (ncli > 2) ? $clog2(ncli) : 1;
  endfunction

endpackage

// File: rtl/sdram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending client at or above
// rr_ptr, wrapping explicitly at NCLI (no power-of-two assumption).
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NCLI = 4,
  parameter int GW   = gw_of(NCLI)
) (
  input  logic [NCLI-1:0] pend,
  input  logic [GW-1:0]   rr_ptr,
  output logic [GW-1:0]   g,
  output logic            any
);

  logic [GW:0] w_idx;

  // Scan from farthest to nearest so the nearest pending client is written last.
  always_comb begin
    any   = |pend;
    g     = '0;
    w_idx = '0;
    for (int k = NCLI - 1; k >= 0; k--) begin
      w_idx = {1'b0, rr_ptr} + (GW + 1)'(k);
      if (w_idx >= (GW + 1)'(NCLI)) begin
        w_idx = w_idx - (GW + 1)'(NCLI);
      end
      if (pend[w_idx[GW-1:0]]) begin
        g = w_idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake sdram port among NCLI
// clients; m_req parity is kept in step with the controller across resets.
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCLI = 4,
  parameter int AW   = 24,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCLI*AW-1:0]   cli_addr,
  input  logic [NCLI-1:0]      cli_wrl,
  input  logic [NCLI-1:0]      cli_wrh,
  input  logic [NCLI*DW-1:0]   cli_din,
  input  logic [NCLI-1:0]      cli_req,
  output logic [NCLI-1:0]      cli_ack,
  output logic [NCLI*DW-1:0]   cli_dout,
  output logic [AW-1:0]        m_addr,
  output logic                 m_wrl,
  output logic                 m_wrh,
  output logic [DW-1:0]        m_din,
  output logic                 m_req,
  input  logic                 m_ack,
  input  logic [DW-1:0]        m_dout,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int GW = gw_of(NCLI);

  // Handshake: a client request is pending while cli_req[i] != cli_ack[i];
  // the master transaction is outstanding while m_req != m_ack.
  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_m_req;
  logic [AW-1:0]             r_m_addr;
  logic [DW-1:0]             r_m_din;
  logic                      r_m_wrl;
  logic                      r_m_wrh;
  logic [GW-1:0]             r_g;
  logic [GW-1:0]             r_rr_ptr;
  logic [NCLI-1:0]           r_cli_ack;
  logic [NCLI-1:0][DW-1:0]   r_cli_dout;

  logic [NCLI-1:0]           w_pend;
  logic [GW-1:0]             w_grant;
  logic                      w_any;
  logic                      w_match;
  logic [AW-1:0]             w_sel_addr;
  logic [DW-1:0]             w_sel_din;
  logic                      w_sel_wrl;
  logic                      w_sel_wrh;

  assign w_pend  = cli_req ^ r_cli_ack;
  assign w_match = (m_ack == r_m_req);

  rr_pick #(
    .NCLI (NCLI),
    .GW   (GW)
  ) u_pick (
    .pend   (w_pend),
    .rr_ptr (r_rr_ptr),
    .g      (w_grant),
    .any    (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_wrl  = 1'b0;
    w_sel_wrh  = 1'b0;
    for (int i = 0; i < NCLI; i++) begin
      if (w_grant == GW'(i)) begin
        w_sel_addr = cli_addr[i*AW +: AW];
        w_sel_din  = cli_din[i*DW +: DW];
        w_sel_wrl  = cli_wrl[i];
        w_sel_wrh  = cli_wrh[i];
      end
    end
  end

  // Reset never abandons a toggle already issued to the controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!reset && w_any) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = reset ? DRAIN : WAIT;
      WAIT: begin
        if (reset)        w_state_nxt = DRAIN;
        else if (w_match) w_state_nxt = IDLE;
      end
      DRAIN:   if (w_match) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
  end

  // Not reset: the controller keeps its own ack parity through our reset.
  always_ff @(posedge clk) begin
    if (r_state == ISSUE) begin
      r_m_req <= ~r_m_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_addr   <= '0;
      r_m_din    <= '0;
      r_m_wrl    <= 1'b0;
      r_m_wrh    <= 1'b0;
      r_g        <= '0;
      r_rr_ptr   <= '0;
      r_cli_ack  <= '0;
      r_cli_dout <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_m_addr <= w_sel_addr;
            r_m_din  <= w_sel_din;
            r_m_wrl  <= w_sel_wrl;
            r_m_wrh  <= w_sel_wrh;
            r_g      <= w_grant;
          end
        end
        WAIT: begin
          if (w_match) begin
            if (!(r_m_wrl || r_m_wrh)) begin
              r_cli_dout[r_g] <= m_dout;
            end
            r_cli_ack[r_g] <= ~r_cli_ack[r_g];
            r_rr_ptr       <= (r_g == GW'(NCLI - 1)) ? '0 : r_g + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_addr    = r_m_addr;
  assign m_din     = r_m_din;
  assign m_wrl     = r_m_wrl;
  assign m_wrh     = r_m_wrh;
  assign m_req     = r_m_req;
  assign cli_ack   = r_cli_ack;
  assign cli_dout  = r_cli_dout;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule
